// File: rtl/vend_ctrl_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : vend_ctrl_param_if
//  Description : Handshake bundle between a vending front panel (coins,
//                selections, cancel, restock) and the vend_ctrl_param core.
//  Revision    : 1.0  initial release
// ============================================================================
interface vend_ctrl_param_if #(
  parameter int IW       = 2,
  parameter int CREDIT_W = 8,
  parameter int STOCK_W  = 4
);
  // Panel -> controller
  logic                coin_valid;
  logic [1:0]          coin_type;
  logic                sel_valid;
  logic [IW-1:0]       sel_idx;
  logic                cancel;
  logic                restock_valid;
  logic [IW-1:0]       restock_idx;
  logic [STOCK_W-1:0]  restock_qty;

  // Controller -> panel
  logic [CREDIT_W-1:0] credit;
  logic                dispense_valid;
  logic [IW-1:0]       dispense_idx;
  logic                change_valid;
  logic [CREDIT_W-1:0] change_amt;
  logic                coin_reject;
  logic                error;
  logic [1:0]          err_code;
  logic                busy;

  modport master (
    output coin_valid, coin_type, sel_valid, sel_idx, cancel,
           restock_valid, restock_idx, restock_qty,
    input  credit, dispense_valid, dispense_idx, change_valid, change_amt,
           coin_reject, error, err_code, busy
  );

  modport slave (
    input  coin_valid, coin_type, sel_valid, sel_idx, cancel,
           restock_valid, restock_idx, restock_qty,
    output credit, dispense_valid, dispense_idx, change_valid, change_amt,
           coin_reject, error, err_code, busy
  );
endinterface
`default_nettype wire

// File: rtl/vend_ctrl_param.sv
`default_nettype none
// ============================================================================
//  Module      : vend_ctrl_param
//  Description : Parameterised vending-machine controller. Accumulates coin
//                credit, validates selections against per-item stock and
//                price, dispenses, returns change, refunds on cancel or idle
//                timeout and accepts restocking at any time.
//  Revision    : 1.0  initial release
// ============================================================================
module vend_ctrl_param #(
  parameter int                          N_ITEMS  = 4,
  parameter int                          CREDIT_W = 8,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES   = {8'd25, 8'd15, 8'd10, 8'd5},
  parameter int                          STOCK_W  = 4,
  parameter int                          TIMEOUT  = 1000
) (
  input  logic             clk,
  input  logic             reset,
  vend_ctrl_param_if.slave bus
);

  localparam int IW = $clog2(N_ITEMS);
  // Sum width must hold the largest coin (25) even for narrow credit widths.
  localparam int SW = ((CREDIT_W > 5) ? CREDIT_W : 5) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [SW-1:0] CREDIT_MAX = {{(SW-CREDIT_W){1'b0}}, {CREDIT_W{1'b1}}};

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CREDIT  = 2'b01;
  localparam logic [1:0] ERR_SOLDOUT = 2'b10;
  localparam logic [1:0] ERR_BADIDX  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CREDIT = 2'd1,
    S_VEND   = 2'd2,
    S_CHANGE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [STOCK_W-1:0]  stock_q [N_ITEMS];
  logic [STOCK_W-1:0]  stock_d [N_ITEMS];
  logic [STOCK_W:0]    stock_sum [N_ITEMS];

  logic                dispense_valid_q, dispense_valid_d;
  logic [IW-1:0]       dispense_idx_q, dispense_idx_d;
  logic                change_valid_q, change_valid_d;
  logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
  logic                coin_reject_q, coin_reject_d;
  logic                error_q, error_d;
  logic [1:0]          err_code_q, err_code_d;

  logic                dispense_en;
  logic                sel_bad;
  logic [CREDIT_W-1:0] sel_price;
  logic [STOCK_W-1:0]  sel_stock;
  logic [SW-1:0]       coin_sum;
  logic                coin_ovf;

  function automatic logic [SW-1:0] coin_value(input logic [1:0] t);
    logic [SW-1:0] v;
    case (t)
      2'b00:   v = SW'(1);
      2'b01:   v = SW'(5);
      2'b10:   v = SW'(10);
      default: v = SW'(25);
    endcase
    return v;
  endfunction

  // An index can only be out of range when N_ITEMS is not a power of two.
  generate
    if (N_ITEMS == (1 << IW)) begin : g_idx_full
      assign sel_bad = 1'b0;
    end else begin : g_idx_partial
      assign sel_bad = (bus.sel_idx >= IW'(N_ITEMS));
    end
  endgenerate

  // Look up price and stock of the currently presented selection.
  always_comb begin
    sel_price = '0;
    sel_stock = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (bus.sel_idx == IW'(i)) begin
        sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
        sel_stock = stock_q[i];
      end
    end
  end

  assign coin_sum = {{(SW-CREDIT_W){1'b0}}, credit_q} + coin_value(bus.coin_type);
  assign coin_ovf = (coin_sum > CREDIT_MAX);

  // Next-state, credit, timeout and pulse decoding.
  always_comb begin
    state_d          = state_q;
    credit_d         = credit_q;
    tmo_d            = tmo_q;
    dispense_valid_d = 1'b0;
    dispense_idx_d   = '0;
    change_valid_d   = 1'b0;
    change_amt_d     = '0;
    coin_reject_d    = 1'b0;
    error_d          = 1'b0;
    err_code_d       = ERR_NONE;
    dispense_en      = 1'b0;

    case (state_q)
      S_IDLE, S_CREDIT: begin
        if (bus.cancel && (state_q == S_CREDIT)) begin
          // Cancel wins; a coin in the same cycle goes back uncredited.
          state_d        = S_CHANGE;
          change_valid_d = 1'b1;
          change_amt_d   = credit_q;
          credit_d       = '0;
          tmo_d          = '0;
          coin_reject_d  = bus.coin_valid;
        end else if (bus.sel_valid) begin
          tmo_d         = '0;
          coin_reject_d = bus.coin_valid;
          if (sel_bad) begin
            error_d    = 1'b1;
            err_code_d = ERR_BADIDX;
          end else if (sel_stock == '0) begin
            error_d    = 1'b1;
            err_code_d = ERR_SOLDOUT;
          end else if (credit_q < sel_price) begin
            error_d    = 1'b1;
            err_code_d = ERR_CREDIT;
          end else begin
            dispense_en      = 1'b1;
            dispense_valid_d = 1'b1;
            dispense_idx_d   = bus.sel_idx;
            credit_d         = credit_q - sel_price;
            state_d          = S_VEND;
          end
        end else if (bus.coin_valid) begin
          tmo_d = '0;
          if (coin_ovf) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = S_CREDIT;
          end
        end else if (state_q == S_CREDIT) begin
          if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d        = S_CHANGE;
            change_valid_d = 1'b1;
            change_amt_d   = credit_q;
            credit_d       = '0;
            tmo_d          = '0;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
      end

      S_VEND: begin
        coin_reject_d = bus.coin_valid;
        tmo_d         = '0;
        if (credit_q != '0) begin
          state_d        = S_CHANGE;
          change_valid_d = 1'b1;
          change_amt_d   = credit_q;
          credit_d       = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CHANGE: begin
        coin_reject_d = bus.coin_valid;
        tmo_d         = '0;
        state_d       = S_IDLE;
      end

      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
        tmo_d    = '0;
      end
    endcase
  end

  // Per-item stock update: dispense removes one unit, restock adds with saturation.
  always_comb begin
    for (int i = 0; i < N_ITEMS; i++) begin
      stock_sum[i] = {1'b0, stock_q[i]}
                   - {{STOCK_W{1'b0}}, (dispense_en && (bus.sel_idx == IW'(i)))}
                   + ((bus.restock_valid && (bus.restock_idx == IW'(i)))
                      ? {1'b0, bus.restock_qty} : '0);
      stock_d[i]   = stock_sum[i][STOCK_W] ? {STOCK_W{1'b1}} : stock_sum[i][STOCK_W-1:0];
    end
  end

  // State, credit, timeout and registered pulse outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      credit_q         <= '0;
      tmo_q            <= '0;
      dispense_valid_q <= 1'b0;
      dispense_idx_q   <= '0;
      change_valid_q   <= 1'b0;
      change_amt_q     <= '0;
      coin_reject_q    <= 1'b0;
      error_q          <= 1'b0;
      err_code_q       <= ERR_NONE;
    end else begin
      state_q          <= state_d;
      credit_q         <= credit_d;
      tmo_q            <= tmo_d;
      dispense_valid_q <= dispense_valid_d;
      dispense_idx_q   <= dispense_idx_d;
      change_valid_q   <= change_valid_d;
      change_amt_q     <= change_amt_d;
      coin_reject_q    <= coin_reject_d;
      error_q          <= error_d;
      err_code_q       <= err_code_d;
    end
  end

  // Stock counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_ITEMS; i++) begin
        stock_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_ITEMS; i++) begin
        stock_q[i] <= stock_d[i];
      end
    end
  end

  assign bus.credit         = credit_q;
  assign bus.dispense_valid = dispense_valid_q;
  assign bus.dispense_idx   = dispense_idx_q;
  assign bus.change_valid   = change_valid_q;
  assign bus.change_amt     = change_amt_q;
  assign bus.coin_reject    = coin_reject_q;
  assign bus.error          = error_q;
  assign bus.err_code       = err_code_q;
  assign bus.busy           = (state_q == S_VEND) || (state_q == S_CHANGE);

endmodule
`default_nettype wire

// File: tb/tb_vend_ctrl_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vend_ctrl_param
//  Description : Self-checking bench for vend_ctrl_param: transaction-level
//                reference model, per-cycle comparison, directed scenarios
//                and randomized traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vend_ctrl_param;

  localparam int TMO = 20;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vend_ctrl_param_if #(.IW(2), .CREDIT_W(8), .STOCK_W(4)) bus_if ();
  vend_ctrl_param_if #(.IW(2), .CREDIT_W(8), .STOCK_W(4)) aux_if ();

  vend_ctrl_param #(
    .N_ITEMS(4), .CREDIT_W(8), .PRICES({8'd25, 8'd15, 8'd10, 8'd5}),
    .STOCK_W(4), .TIMEOUT(TMO)
  ) u_dut (.clk(clk), .reset(reset), .bus(bus_if));

  vend_ctrl_param #(
    .N_ITEMS(3), .CREDIT_W(8), .PRICES({8'd15, 8'd10, 8'd5}),
    .STOCK_W(4), .TIMEOUT(1000)
  ) u_aux (.clk(clk), .reset(reset), .bus(aux_if));

  int n_total = 0;
  int n_pass  = 0;
  bit run_cmp = 1'b0;

  // ---------------- reference model (transaction level) ----------------
  int price_tab [4] = '{5, 10, 15, 25};
  int coin_tab  [4] = '{1, 5, 10, 25};
  int m_credit      = 0;
  int m_stock   [4] = '{0, 0, 0, 0};
  int m_idle        = 0;
  bit m_vend        = 1'b0;   // current cycle shows a dispense, remainder pending
  bit m_refund      = 1'b0;   // current cycle shows a change pulse
  bit e_disp = 0, e_chg = 0, e_rej = 0, e_err = 0;
  int e_didx = 0, e_amt = 0, e_code = 0;

  task automatic m_pay_out();
    e_chg    = 1'b1;
    e_amt    = m_credit;
    m_credit = 0;
    m_idle   = 0;
    m_refund = 1'b1;
  endtask

  task automatic model_step();
    bit c_v, s_v, x_v, r_v;
    int ct, si, ri, rq, took, n;
    c_v = bus_if.coin_valid;    ct = int'(bus_if.coin_type);
    s_v = bus_if.sel_valid;     si = int'(bus_if.sel_idx);
    x_v = bus_if.cancel;
    r_v = bus_if.restock_valid; ri = int'(bus_if.restock_idx); rq = int'(bus_if.restock_qty);
    e_disp = 0; e_chg = 0; e_rej = 0; e_err = 0; e_didx = 0; e_amt = 0; e_code = 0;
    took = -1;
    if (reset) begin
      m_credit = 0; m_idle = 0; m_vend = 0; m_refund = 0;
      for (int i = 0; i < 4; i++) m_stock[i] = 0;
      return;
    end
    if (m_vend) begin
      e_rej  = c_v;
      m_vend = 1'b0;
      if (m_credit > 0) m_pay_out();
    end else if (m_refund) begin
      e_rej    = c_v;
      m_refund = 1'b0;
    end else if (x_v && m_credit > 0) begin
      e_rej = c_v;
      m_pay_out();
    end else if (s_v) begin
      m_idle = 0;
      e_rej  = c_v;
      if (si >= 4) begin e_err = 1; e_code = 3; end
      else if (m_stock[si] == 0) begin e_err = 1; e_code = 2; end
      else if (m_credit < price_tab[si]) begin e_err = 1; e_code = 1; end
      else begin
        e_disp   = 1; e_didx = si;
        m_credit = m_credit - price_tab[si];
        took     = si;
        m_vend   = 1'b1;
      end
    end else if (c_v) begin
      m_idle = 0;
      if (m_credit + coin_tab[ct] > 255) e_rej = 1;
      else m_credit = m_credit + coin_tab[ct];
    end else if (m_credit > 0) begin
      m_idle++;
      if (m_idle == TMO) m_pay_out();
    end
    for (int i = 0; i < 4; i++) begin
      n = m_stock[i] - ((took == i) ? 1 : 0) + ((r_v && ri == i) ? rq : 0);
      m_stock[i] = (n > 15) ? 15 : n;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (run_cmp && !reset) begin
        bit ok;
        ok = (int'(bus_if.credit) == m_credit)
          && (bus_if.busy == (m_vend || m_refund))
          && (bus_if.dispense_valid == e_disp)
          && (!e_disp || int'(bus_if.dispense_idx) == e_didx)
          && (bus_if.change_valid == e_chg)
          && (!e_chg || int'(bus_if.change_amt) == e_amt)
          && (bus_if.coin_reject == e_rej)
          && (bus_if.error == e_err)
          && (!e_err || int'(bus_if.err_code) == e_code);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL cycle@%0t: dut credit=%0d busy=%0d disp=%0d/%0d chg=%0d/%0d rej=%0d err=%0d/%0d | model credit=%0d busy=%0d disp=%0d/%0d chg=%0d/%0d rej=%0d err=%0d/%0d",
                      $time, bus_if.credit, bus_if.busy, bus_if.dispense_valid, bus_if.dispense_idx,
                      bus_if.change_valid, bus_if.change_amt, bus_if.coin_reject, bus_if.error, bus_if.err_code,
                      m_credit, (m_vend || m_refund), e_disp, e_didx, e_chg, e_amt, e_rej, e_err, e_code);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic clr_main();
    bus_if.coin_valid = 0; bus_if.sel_valid = 0; bus_if.cancel = 0; bus_if.restock_valid = 0;
  endtask

  task automatic clr_aux();
    aux_if.coin_valid = 0; aux_if.sel_valid = 0; aux_if.cancel = 0; aux_if.restock_valid = 0;
  endtask

  task automatic do_coin(input int t);
    bus_if.coin_valid = 1; bus_if.coin_type = 2'(t);
    @(negedge clk); clr_main();
  endtask

  task automatic do_sel(input int idx);
    bus_if.sel_valid = 1; bus_if.sel_idx = 2'(idx);
    @(negedge clk); clr_main();
  endtask

  task automatic do_restock(input int idx, input int qty);
    bus_if.restock_valid = 1; bus_if.restock_idx = 2'(idx); bus_if.restock_qty = 4'(qty);
    @(negedge clk); clr_main();
  endtask

  task automatic do_cancel();
    bus_if.cancel = 1;
    @(negedge clk); clr_main();
  endtask

  task automatic aux_sel(input int idx);
    aux_if.sel_valid = 1; aux_if.sel_idx = 2'(idx);
    @(negedge clk); clr_aux();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clr_main(); clr_aux();
    bus_if.coin_type = 0; bus_if.sel_idx = 0; bus_if.restock_idx = 0; bus_if.restock_qty = 0;
    aux_if.coin_type = 0; aux_if.sel_idx = 0; aux_if.restock_idx = 0; aux_if.restock_qty = 0;

    // Asynchronous reset takes effect without a clock edge.
    #3 reset = 1'b1;
    #1;
    chk("reset_credit", int'(bus_if.credit), 0);
    chk("reset_pulses", int'({bus_if.dispense_valid, bus_if.change_valid, bus_if.coin_reject,
                              bus_if.error, bus_if.busy}), 0);
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    run_cmp = 1'b1;

    // Out-of-range and sold-out errors on a 3-item instance.
    aux_if.coin_valid = 1; aux_if.coin_type = 2'd1;
    @(negedge clk); clr_aux();
    chk("aux_credit5", int'(aux_if.credit), 5);
    aux_sel(3);
    chk("aux_badidx_err", int'(aux_if.error), 1);
    chk("aux_badidx_code", int'(aux_if.err_code), 3);
    aux_sel(2);
    chk("aux_soldout_code", int'(aux_if.err_code), 2);
    chk("aux_credit_kept", int'(aux_if.credit), 5);

    // Exact payment: restock 2 x3, coins 10+5, select item 2.
    do_restock(2, 3);
    do_coin(2); do_coin(1);
    chk("exact_credit15", int'(bus_if.credit), 15);
    do_sel(2);
    chk("exact_disp", int'(bus_if.dispense_valid), 1);
    chk("exact_idx", int'(bus_if.dispense_idx), 2);
    chk("exact_credit0", int'(bus_if.credit), 0);
    @(negedge clk);
    chk("exact_no_change", int'(bus_if.change_valid), 0);
    chk("exact_not_busy", int'(bus_if.busy), 0);
    chk("model_stock2", m_stock[2], 2);

    // Change: coins 25+5, select item 0 (price 5) -> change 25 one cycle later.
    do_restock(0, 5);
    do_coin(3); do_coin(1);
    do_sel(0);
    chk("chg_disp_idx", int'(bus_if.dispense_idx), 0);
    chk("chg_not_yet", int'(bus_if.change_valid), 0);
    @(negedge clk);
    chk("chg_valid", int'(bus_if.change_valid), 1);
    chk("chg_amt", int'(bus_if.change_amt), 25);
    chk("model_chg_amt", e_amt, 25);
    @(negedge clk);
    chk("chg_idle", int'(bus_if.busy), 0);

    // Selection errors with credit 5.
    do_coin(1);
    do_restock(3, 2);
    do_sel(3);
    chk("err_credit_code", int'(bus_if.err_code), 1);
    chk("err_credit_kept", int'(bus_if.credit), 5);
    do_sel(1);
    chk("err_soldout_code", int'(bus_if.err_code), 2);
    do_cancel();
    chk("cancel_amt", int'(bus_if.change_amt), 5);
    @(negedge clk);

    // Overflow guard at credit 250, then cancel racing a coin.
    repeat (10) do_coin(3);
    chk("ovf_credit250", int'(bus_if.credit), 250);
    do_coin(2);
    chk("ovf_reject", int'(bus_if.coin_reject), 1);
    chk("ovf_credit_kept", int'(bus_if.credit), 250);
    bus_if.cancel = 1; bus_if.coin_valid = 1; bus_if.coin_type = 2'd0;
    @(negedge clk); clr_main();
    chk("race_chg_amt", int'(bus_if.change_amt), 250);
    chk("race_reject", int'(bus_if.coin_reject), 1);
    @(negedge clk);

    // Idle timeout refunds credit 7 after TMO quiet cycles.
    do_coin(1); do_coin(0); do_coin(0);
    chk("tmo_credit7", int'(bus_if.credit), 7);
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_early", int'(bus_if.change_valid), 0);
    @(negedge clk);
    chk("tmo_valid", int'(bus_if.change_valid), 1);
    chk("tmo_amt", int'(bus_if.change_amt), 7);
    @(negedge clk);

    // Reset while vending discards the pending change.
    do_restock(1, 1);
    do_coin(3);
    do_sel(1);
    chk("rv_disp", int'(bus_if.dispense_valid), 1);
    chk("rv_credit15", int'(bus_if.credit), 15);
    #1 reset = 1'b1;
    #1;
    chk("rv_async_zero", int'({bus_if.dispense_valid, bus_if.change_valid, bus_if.busy,
                               bus_if.coin_reject, bus_if.error}), 0);
    chk("rv_async_credit", int'(bus_if.credit), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rv_no_change", int'(bus_if.change_valid), 0);
    chk("rv_idle", int'(bus_if.busy), 0);
    chk("model_reset_credit", m_credit, 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        clr_main();
        repeat (TMO + 5) @(negedge clk);
      end
      bus_if.coin_valid    = ($urandom_range(0, 99) < 30);
      bus_if.coin_type     = 2'($urandom_range(0, 3));
      bus_if.sel_valid     = ($urandom_range(0, 99) < 12);
      bus_if.sel_idx       = 2'($urandom_range(0, 3));
      bus_if.cancel        = ($urandom_range(0, 99) < 3);
      bus_if.restock_valid = ($urandom_range(0, 99) < 8);
      bus_if.restock_idx   = 2'($urandom_range(0, 3));
      bus_if.restock_qty   = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    clr_main();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vend_ctrl_param.md
VEND_CTRL_PARAM -- requirements
Module: vend_ctrl_param

Interface
REQ-001 The block SHALL take parameter N_ITEMS, default 4: number of selectable products, legal range 2..16.
REQ-002 The block SHALL take parameter CREDIT_W, default 8: width of credit, price and change values.
REQ-003 The block SHALL take parameter PRICES, default {8'd25,8'd15,8'd10,8'd5}: packed N_ITEMS*CREDIT_W vector, item i price at [i*CREDIT_W +: CREDIT_W].
REQ-004 The block SHALL take parameter STOCK_W, default 4: width of each per-item stock counter.
REQ-005 The block SHALL take parameter TIMEOUT, default 1000: idle cycles with nonzero credit before auto-refund.
REQ-006 The block SHALL have port clk, input, 1: rising-edge clock.
REQ-007 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 The block SHALL have port coin_valid, input, 1: single-cycle coin strobe.
REQ-009 The block SHALL have port coin_type, input, 2: 00=1, 01=5, 10=10, 11=25 credit units.
REQ-010 The block SHALL have port sel_valid, input, 1: product selection strobe.
REQ-011 The block SHALL have port sel_idx, input, IW=$clog2(N_ITEMS): selected item index.
REQ-012 The block SHALL have port cancel, input, 1: refund request.
REQ-013 The block SHALL have port restock_valid, input, 1: restock strobe.
REQ-014 The block SHALL have port restock_idx, input, IW: item index to restock.
REQ-015 The block SHALL have port restock_qty, input, STOCK_W: units added on restock.
REQ-016 The block SHALL have port credit, output, CREDIT_W: current credit register.
REQ-017 The block SHALL have port dispense_valid, output, 1: single-cycle dispense pulse.
REQ-018 The block SHALL have port dispense_idx, output, IW: item dispensed, valid with dispense_valid.
REQ-019 The block SHALL have port change_valid, output, 1: single-cycle change/refund pulse.
REQ-020 The block SHALL have port change_amt, output, CREDIT_W: amount returned, valid with change_valid.
REQ-021 The block SHALL have port coin_reject, output, 1: single-cycle pulse indicating the coin is returned uncredited.
REQ-022 The block SHALL have port error, output, 1: single-cycle selection-error pulse.
REQ-023 The block SHALL have port err_code, output, 2: 01 insufficient credit, 10 sold out, 11 bad index; valid with error.
REQ-024 The block SHALL have port busy, output, 1: high in states VEND and CHANGE.

Function
REQ-025 The FSM SHALL have states IDLE (credit==0), CREDIT (credit>0), VEND and CHANGE, all registered on clk.
REQ-026 In IDLE/CREDIT, a coin SHALL add its value to credit on the next edge; a sum exceeding 2^CREDIT_W-1 SHALL instead pulse coin_reject with credit unchanged (no wrap).
REQ-027 A coin arriving in VEND/CHANGE SHALL pulse coin_reject with credit unchanged.
REQ-028 A selection in IDLE/CREDIT SHALL be checked in the priority order bad index (sel_idx>=N_ITEMS), then stock==0, then credit<price; a failure SHALL pulse error with the matching err_code, retain credit and keep the state.
REQ-029 A valid selection at edge t SHALL produce dispense_valid and dispense_idx at t+1, decrement stock and subtract the price from credit, with the state at VEND.
REQ-030 Leaving VEND with remainder>0 SHALL pulse change_valid with change_amt=remainder at t+2 and clear credit; with remainder==0 the FSM SHALL return to IDLE without a change pulse.
REQ-031 cancel in CREDIT SHALL enter CHANGE and refund the full credit on the next cycle; cancel in IDLE SHALL be ignored.
REQ-032 Same-cycle strobes SHALL be resolved as cancel > sel_valid > coin_valid; a losing coin SHALL pulse coin_reject and a losing selection SHALL be dropped silently.
REQ-033 sel_valid and cancel SHALL be ignored while busy=1.
REQ-034 The timeout counter SHALL clear on any coin, selection or cancel; after TIMEOUT consecutive idle cycles in CREDIT the block SHALL enter CHANGE and refund the full credit.
REQ-035 Restock SHALL be accepted in any state, saturating at 2^STOCK_W-1; if it coincides with a dispense of the same item, the result SHALL be sat(old-1+qty).
REQ-036 Every pulse output SHALL be high for exactly one cycle per event.

Reset
REQ-037 Assertion of reset SHALL immediately force state IDLE, credit=0, all stock=0, timeout counter=0 and all outputs 0.
REQ-038 A reset during VEND/CHANGE SHALL discard the pending dispense/change with no pulse; normal operation SHALL resume on the first clk edge after deassertion.

Verification
REQ-039 Restock item 2 qty 3; coins 10,5 (credit 15); select 2 (price 15) -> dispense_valid idx 2 at t+1, no change pulse, credit 0, stock[2]=2.
REQ-040 Coins 25,5; select 0 (price 5) -> dispense idx 0 at t+1, change_valid change_amt 25 at t+2, then IDLE.
REQ-041 Credit 5, select 3 (price 25, stocked) -> error, err_code 01, credit stays 5; select unstocked item -> err_code 10; sel_idx out of range with N_ITEMS=3 -> err_code 11.
REQ-042 Credit 250 with CREDIT_W=8, coin 10 -> coin_reject, credit 250; cancel plus coin in the same cycle -> change_amt 250 and coin_reject.
REQ-043 Credit 7, TIMEOUT=20, no activity -> change_valid amt 7 after 20 cycles; repeat with reset asserted during VEND -> no pulses, all outputs 0.
